// File: rtl/ddr_ctrl_pkg.sv
// Shared definitions for the DDR user write path (user_wr_feed, user_wr_ctrl).
// Holds the write-path state encoding, bus widths and the default burst,
// frame and end-timeout sizes for a 1024x768x16-bit frame of 128-bit words.
package ddr_ctrl_pkg;
  localparam int BURST_LEN_DEF        = 64;
  localparam int BURSTS_PER_FRAME_DEF = 1536;
  localparam int END_TIMEOUT_DEF      = 4096;

  localparam int DATA_W      = 128;
  localparam int RD_COUNT_W  = 10;
  localparam int BEAT_W      = 7;
  localparam int BURST_CNT_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BURST,
    DRAIN,
    WAIT_END
  } wr_state_t;
endpackage

// File: rtl/user_wr_feed_if.sv
// Bus bundle between the capture FIFO / arbiter / user_wr_ctrl and user_wr_feed.
//   master : user_wr_feed side (drives FIFO read strobe, request, write beat, status)
//   slave  : environment side (FIFO level/data, grant, burst-complete pulse)
interface user_wr_feed_if;
  import ddr_ctrl_pkg::*;

  logic [RD_COUNT_W-1:0] fifo_rd_count;
  logic [DATA_W-1:0]     fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  wr_req;
  logic                  wr_grant;
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  user_wr_end;
  logic                  wr_busy;
  logic                  frame_done;
  logic                  wr_err;

  modport master (
    input  fifo_rd_count, fifo_rd_data, wr_grant, user_wr_end,
    output fifo_rd_en, wr_req, wr_en, wr_data, wr_busy, frame_done, wr_err
  );

  modport slave (
    output fifo_rd_count, fifo_rd_data, wr_grant, user_wr_end,
    input  fifo_rd_en, wr_req, wr_en, wr_data, wr_busy, frame_done, wr_err
  );
endinterface

// File: rtl/user_wr_feed.sv
// Moves one BURST_LEN-word burst at a time from the capture FIFO into
// user_wr_ctrl once the arbiter grants the DDR port.
//   sclk, rst : clock, asynchronous active-high reset
//   bus       : user_wr_feed_if.master
//     fifo_rd_count/fifo_rd_data/fifo_rd_en : upstream FIFO read side
//     wr_req/wr_grant                       : arbiter handshake
//     wr_en/wr_data/user_wr_end             : burst to user_wr_ctrl
//     wr_busy/frame_done/wr_err             : status
module user_wr_feed
  import ddr_ctrl_pkg::*;
#(
  parameter int BURST_LEN        = BURST_LEN_DEF,
  parameter int BURSTS_PER_FRAME = BURSTS_PER_FRAME_DEF,
  parameter int END_TIMEOUT      = END_TIMEOUT_DEF
) (
  input  logic           sclk,
  input  logic           rst,
  user_wr_feed_if.master bus
);
  localparam int TO_W = $clog2(END_TIMEOUT + 1);

  wr_state_t              state, state_nxt;
  logic [BEAT_W-1:0]      beat;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic                   rd_en, req, busy;
  logic                   wr_en_q, frame_done_q, wr_err_q;
  logic                   last_beat, end_ok, timeout, wrap;

  assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
  // user_wr_end only counts while a burst is outstanding
  assign end_ok    = (state == WAIT_END) && bus.user_wr_end;
  // a real end pulse on the final timeout cycle still wins over the timeout
  assign timeout   = (state == WAIT_END) && !bus.user_wr_end &&
                     (to_cnt == TO_W'(END_TIMEOUT - 1));
  assign wrap      = end_ok && (burst_cnt == BURST_CNT_W'(BURSTS_PER_FRAME - 1));

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // grant is only looked at in REQ, so dropping it later never aborts a burst
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    req       = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:     if (bus.fifo_rd_count >= RD_COUNT_W'(BURST_LEN)) state_nxt = REQ;
      REQ: begin
        req = 1'b1;
        if (bus.wr_grant) state_nxt = BURST;
      end
      BURST: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (last_beat) state_nxt = DRAIN;
      end
      // last FIFO word is on fifo_rd_data now; wr_en covers it this cycle
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = WAIT_END;
      end
      WAIT_END: begin
        busy = 1'b1;
        if (end_ok || timeout) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      beat         <= '0;
      to_cnt       <= '0;
      burst_cnt    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      beat    <= (state == BURST && !last_beat) ? beat + BEAT_W'(1) : '0;
      to_cnt  <= (state == WAIT_END) ? to_cnt + TO_W'(1) : '0;
      if (end_ok) burst_cnt <= wrap ? '0 : burst_cnt + BURST_CNT_W'(1);
      // FIFO data lands one cycle after the read strobe
      wr_en_q      <= rd_en;
      frame_done_q <= wrap;
      if (timeout) wr_err_q <= 1'b1;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.wr_req     = req;
  assign bus.wr_busy    = busy;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_data    = bus.fifo_rd_data;
  assign bus.frame_done = frame_done_q;
  assign bus.wr_err     = wr_err_q;
endmodule

// File: tb/tb_user_wr_feed.sv
// Self-checking bench for user_wr_feed: random FIFO contents, grant delays and
// end-pulse delays, scored against a burst-level model (FIFO order, frame
// position counter, timeout rules).
module tb_user_wr_feed;
  localparam int TB_BL  = 64;
  localparam int TB_BPF = 6;
  localparam int TB_TO  = 4096;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  always #5 sclk = ~sclk;

  user_wr_feed_if bus ();

  user_wr_feed #(
    .BURST_LEN       (TB_BL),
    .BURSTS_PER_FRAME(TB_BPF),
    .END_TIMEOUT     (TB_TO)
  ) dut (
    .sclk(sclk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int req, rd, rd_early, wen, runs, first_rd, first_wen, derr;
    int busy, fd, waitc, err_at, errc, cyc, last_req, done;
  } obs_t;

  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;
  logic [127:0] fifo_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] fifo_w;

  // FIFO model: data appears one cycle after the read strobe, in push order
  always @(posedge sclk) begin
    if (bus.fifo_rd_en) begin
      fifo_w = (fifo_q.size() > 0) ? fifo_q.pop_front() : {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(fifo_w);
      bus.fifo_rd_data <= fifo_w;
    end
  end

  // Runs one burst from request to return-to-idle, recording what was seen.
  task automatic do_burst(input int gdelay, input int edelay, input bit send_end,
                          input bit drop_grant, input bit stray_end, output obs_t o);
    bit granted, prev_wen, in_wait;
    logic [127:0] ew;
    o = '{default: 0};
    o.first_rd = -1; o.first_wen = -1; o.err_at = -1;
    for (int k = 0; k < TB_BL; k++) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
    bus.fifo_rd_count = 10'(TB_BL + $urandom_range(0, 200));
    bus.wr_grant = (gdelay == 0);
    bus.user_wr_end = 1'b0;
    granted = (gdelay == 0);
    prev_wen = 1'b0;
    for (int c = 0; c < TB_TO + 400; c++) begin
      @(negedge sclk);
      o.cyc++;
      if (bus.wr_req) o.req++;
      if (bus.fifo_rd_en) begin
        o.rd++;
        if (o.first_rd < 0) o.first_rd = c;
        if (!granted) o.rd_early++;
      end
      if (bus.wr_en) begin
        o.wen++;
        if (!prev_wen) o.runs++;
        if (o.first_wen < 0) o.first_wen = c;
        if (exp_q.size() == 0) o.derr++;
        else begin
          ew = exp_q.pop_front();
          if (bus.wr_data !== ew) o.derr++;
        end
      end
      if (bus.wr_busy) o.busy++;
      if (bus.frame_done) o.fd++;
      if (bus.wr_err) begin
        o.errc++;
        if (o.err_at < 0) o.err_at = o.waitc;
      end
      in_wait = bus.wr_busy && !bus.wr_en && (o.wen > 0);
      if (in_wait) o.waitc++;
      prev_wen = bus.wr_en;
      if (o.busy > 0 && !bus.wr_busy) begin
        o.last_req = bus.wr_req;
        o.done = 1;
        bus.user_wr_end = 1'b0;
        break;
      end
      if (!granted && o.req >= gdelay) begin
        bus.wr_grant = 1'b1;
        granted = 1'b1;
      end
      if (drop_grant && o.rd > 0) bus.wr_grant = 1'b0;
      bus.user_wr_end = (stray_end && o.rd == 10) ||
                        (send_end && in_wait && o.waitc == edelay + 1);
    end
  endtask

  task automatic test_reset;
    bus.fifo_rd_count = 10'd100; bus.wr_grant = 1'b1; bus.user_wr_end = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge sclk);
    n_vec++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL reset wr_req: got %b want 0", bus.wr_req); end
    n_vec++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset fifo_rd_en: got %b want 0", bus.fifo_rd_en); end
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL reset wr_en: got %b want 0", bus.wr_en); end
    n_vec++; if (bus.wr_busy !== 1'b0) begin n_err++; $display("FAIL reset wr_busy: got %b want 0", bus.wr_busy); end
    n_vec++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset frame_done: got %b want 0", bus.frame_done); end
    n_vec++; if (bus.wr_err !== 1'b0) begin n_err++; $display("FAIL reset wr_err: got %b want 0", bus.wr_err); end
    bus.fifo_rd_count = 10'd0;
    @(negedge sclk);
    rst = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_threshold;
    int reqs = 0, rds = 0, efd;
    obs_t o;
    bus.fifo_rd_count = 10'd63; bus.wr_grant = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge sclk);
      if (bus.wr_req) reqs++;
      if (bus.fifo_rd_en) rds++;
      bus.user_wr_end = (c == 5);  // stray end while idle must be ignored
    end
    bus.user_wr_end = 1'b0;
    n_vec++; if (reqs !== 0) begin n_err++; $display("FAIL thresh63 wr_req cycles: got %0d want 0", reqs); end
    n_vec++; if (rds !== 0) begin n_err++; $display("FAIL thresh63 rd_en cycles: got %0d want 0", rds); end
    bus.fifo_rd_count = 10'd64;
    @(negedge sclk);
    n_vec++; if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL thresh64 wr_req next cycle: got %b want 1", bus.wr_req); end
    do_burst(0, 0, 1'b1, 1'b0, 1'b0, o);
    efd = (model_cnt == TB_BPF - 1); model_cnt = (model_cnt + 1) % TB_BPF;
    n_vec++; if (o.rd !== TB_BL || o.derr !== 0) begin n_err++; $display("FAIL thresh64 burst rd/derr: got %0d/%0d want %0d/0", o.rd, o.derr, TB_BL); end
    n_vec++; if (o.fd !== efd) begin n_err++; $display("FAIL thresh64 frame_done: got %0d want %0d", o.fd, efd); end
  endtask

  task automatic test_basic;
    obs_t o;
    int ed, efd;
    for (int b = 0; b < 3; b++) begin
      ed = $urandom_range(0, 6);
      do_burst(0, ed, 1'b1, 1'b0, 1'b0, o);
      efd = (model_cnt == TB_BPF - 1); model_cnt = (model_cnt + 1) % TB_BPF;
      n_vec++; if (o.done !== 1) begin n_err++; $display("FAIL basic%0d completion: got %0d want 1", b, o.done); end
      n_vec++; if (o.req !== 1) begin n_err++; $display("FAIL basic%0d wr_req cycles: got %0d want 1", b, o.req); end
      n_vec++; if (o.rd !== TB_BL) begin n_err++; $display("FAIL basic%0d rd_en cycles: got %0d want %0d", b, o.rd, TB_BL); end
      n_vec++; if (o.wen !== TB_BL || o.runs !== 1) begin n_err++; $display("FAIL basic%0d wr_en cycles/runs: got %0d/%0d want %0d/1", b, o.wen, o.runs, TB_BL); end
      n_vec++; if (o.first_wen !== o.first_rd + 1) begin n_err++; $display("FAIL basic%0d wr_en lag: got %0d want %0d", b, o.first_wen, o.first_rd + 1); end
      n_vec++; if (o.derr !== 0) begin n_err++; $display("FAIL basic%0d data order errors: got %0d want 0", b, o.derr); end
      n_vec++; if (o.busy !== TB_BL + 1 + ed + 1) begin n_err++; $display("FAIL basic%0d wr_busy cycles: got %0d want %0d", b, o.busy, TB_BL + ed + 2); end
      n_vec++; if (o.fd !== efd) begin n_err++; $display("FAIL basic%0d frame_done: got %0d want %0d", b, o.fd, efd); end
    end
  endtask

  task automatic test_grant_delay;
    obs_t o;
    int gd, efd;
    for (int b = 0; b < 2; b++) begin
      gd = (b == 0) ? 20 : $urandom_range(2, 30);
      do_burst(gd, 1, 1'b1, 1'b0, 1'b0, o);
      efd = (model_cnt == TB_BPF - 1); model_cnt = (model_cnt + 1) % TB_BPF;
      n_vec++; if (o.req !== gd) begin n_err++; $display("FAIL gdelay%0d wr_req cycles: got %0d want %0d", gd, o.req, gd); end
      n_vec++; if (o.rd_early !== 0) begin n_err++; $display("FAIL gdelay%0d reads before grant: got %0d want 0", gd, o.rd_early); end
      n_vec++; if (o.rd !== TB_BL || o.derr !== 0) begin n_err++; $display("FAIL gdelay%0d rd/derr: got %0d/%0d want %0d/0", gd, o.rd, o.derr, TB_BL); end
      n_vec++; if (o.fd !== efd) begin n_err++; $display("FAIL gdelay%0d frame_done: got %0d want %0d", gd, o.fd, efd); end
    end
  endtask

  task automatic test_grant_drop;
    obs_t o;
    int efd;
    do_burst(0, 3, 1'b1, 1'b1, 1'b1, o);
    efd = (model_cnt == TB_BPF - 1); model_cnt = (model_cnt + 1) % TB_BPF;
    n_vec++; if (o.rd !== TB_BL || o.wen !== TB_BL) begin n_err++; $display("FAIL gdrop rd/wen: got %0d/%0d want %0d/%0d", o.rd, o.wen, TB_BL, TB_BL); end
    n_vec++; if (o.waitc !== 4) begin n_err++; $display("FAIL gdrop stray end wait cycles: got %0d want 4", o.waitc); end
    n_vec++; if (o.fd !== efd) begin n_err++; $display("FAIL gdrop frame_done: got %0d want %0d", o.fd, efd); end
  endtask

  task automatic test_timeout;
    obs_t o;
    int efd;
    do_burst(0, 0, 1'b0, 1'b0, 1'b0, o);  // model counter stays put on timeout
    n_vec++; if (o.done !== 1 || o.waitc !== TB_TO) begin n_err++; $display("FAIL timeout wait cycles: got %0d (done %0d) want %0d", o.waitc, o.done, TB_TO); end
    n_vec++; if (o.err_at !== TB_TO) begin n_err++; $display("FAIL timeout wr_err first seen at wait %0d want %0d", o.err_at, TB_TO); end
    n_vec++; if (o.fd !== 0) begin n_err++; $display("FAIL timeout frame_done: got %0d want 0", o.fd); end
    do_burst(0, 2, 1'b1, 1'b0, 1'b0, o);
    efd = (model_cnt == TB_BPF - 1); model_cnt = (model_cnt + 1) % TB_BPF;
    n_vec++; if (o.errc !== o.cyc) begin n_err++; $display("FAIL sticky wr_err cycles: got %0d want %0d", o.errc, o.cyc); end
    n_vec++; if (o.fd !== efd || o.rd !== TB_BL) begin n_err++; $display("FAIL post-timeout fd/rd: got %0d/%0d want %0d/%0d", o.fd, o.rd, efd, TB_BL); end
  endtask

  task automatic test_frame;
    obs_t o;
    int efd, total = 0, want = 0;
    for (int b = 0; b < TB_BPF; b++) begin
      do_burst($urandom_range(0, 3), $urandom_range(0, 4), 1'b1, 1'b0, 1'b0, o);
      efd = (model_cnt == TB_BPF - 1); model_cnt = (model_cnt + 1) % TB_BPF;
      total += o.fd; want += efd;
      n_vec++; if (o.fd !== efd) begin n_err++; $display("FAIL frame burst%0d frame_done: got %0d want %0d", b, o.fd, efd); end
    end
    n_vec++; if (total !== want) begin n_err++; $display("FAIL frame frame_done total: got %0d want %0d", total, want); end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    int efd;
    for (int b = 0; b < 3; b++) begin
      do_burst(0, $urandom_range(0, 2), 1'b1, 1'b0, 1'b0, o);
      efd = (model_cnt == TB_BPF - 1); model_cnt = (model_cnt + 1) % TB_BPF;
      n_vec++; if (o.last_req !== 0) begin n_err++; $display("FAIL b2b%0d wr_req right after end: got %0d want 0", b, o.last_req); end
      n_vec++; if (o.runs !== 1 || o.derr !== 0 || o.fd !== efd) begin n_err++; $display("FAIL b2b%0d runs/derr/fd: got %0d/%0d/%0d want 1/0/%0d", b, o.runs, o.derr, o.fd, efd); end
    end
  endtask

  task automatic test_reset_mid;
    int rdc = 0;
    bit hit = 0;
    for (int k = 0; k < TB_BL; k++) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
    bus.fifo_rd_count = 10'd100; bus.wr_grant = 1'b1; bus.user_wr_end = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge sclk);
      if (bus.fifo_rd_en) rdc++;
      if (rdc == 30) begin hit = 1; break; end
    end
    n_vec++; if (hit !== 1) begin n_err++; $display("FAIL rstmid reached beat 30: got %0d want 1", hit); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid wr_en: got %b want 0", bus.wr_en); end
    n_vec++; if (bus.fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL rstmid fifo_rd_en: got %b want 0", bus.fifo_rd_en); end
    n_vec++; if (bus.wr_busy !== 1'b0) begin n_err++; $display("FAIL rstmid wr_busy: got %b want 0", bus.wr_busy); end
    n_vec++; if (bus.wr_err !== 1'b0) begin n_err++; $display("FAIL rstmid wr_err: got %b want 0", bus.wr_err); end
    bus.fifo_rd_count = 10'd0;
    exp_q.delete();
    model_cnt = 0;
    @(negedge sclk);
    rst = 1'b0;
  endtask

  initial begin
    bus.fifo_rd_count = '0;
    bus.wr_grant = 1'b0;
    bus.user_wr_end = 1'b0;
    test_reset();
    test_threshold();
    test_basic();
    test_grant_delay();
    test_grant_drop();
    test_timeout();
    test_frame();
    test_back_to_back();
    test_reset_mid();
    test_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/user_wr_feed.md
USER_WR_FEED -- requirements
Module: user_wr_feed

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64: 128-bit words per write burst.
REQ-002 SHALL have parameter BURSTS_PER_FRAME, default 1536: bursts per 1024x768x16-bit frame.
REQ-003 SHALL have parameter END_TIMEOUT, default 4096: maximum sclk cycles to wait for user_wr_end.
REQ-004 sclk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 fifo_rd_count  input  10  words available in the upstream capture FIFO (read side).
REQ-007 fifo_rd_data  input  128  FIFO output, valid one cycle after fifo_rd_en.
REQ-008 fifo_rd_en  output  1  FIFO read strobe.
REQ-009 wr_req  output  1  request for the DDR port from the read/write arbiter.
REQ-010 wr_grant  input  1  arbiter grant, level.
REQ-011 wr_en  output  1  write strobe to user_wr_ctrl.
REQ-012 wr_data  output  128  write data to user_wr_ctrl.
REQ-013 user_wr_end  input  1  single-cycle burst-complete pulse from user_wr_ctrl.
REQ-014 wr_busy  output  1  high from grant until burst completion or timeout.
REQ-015 frame_done  output  1  single-cycle pulse after the last burst of a frame.
REQ-016 wr_err  output  1  sticky end-timeout flag, cleared only by rst.

Function
REQ-017 SHALL implement states IDLE, REQ, BURST, DRAIN, WAIT_END.
REQ-018 IDLE->REQ when fifo_rd_count >= BURST_LEN; wr_req SHALL be high exactly in REQ.
REQ-019 REQ->BURST on wr_grant high; REQ SHALL hold indefinitely while wr_grant low.
REQ-020 In BURST, fifo_rd_en SHALL be high for exactly BURST_LEN consecutive cycles; 7-bit beat counter 0..BURST_LEN-1, then DRAIN.
REQ-021 wr_en SHALL equal fifo_rd_en delayed one cycle; wr_data SHALL equal fifo_rd_data, combinational from FIFO output. wr_en therefore forms one unbroken BURST_LEN-cycle pulse with no gaps.
REQ-022 DRAIN SHALL last one cycle (last beat issued), then WAIT_END.
REQ-023 WAIT_END->IDLE on user_wr_end; the burst counter SHALL increment in the same cycle.
REQ-024 Burst counter (11 bits) SHALL wrap from BURSTS_PER_FRAME-1 to 0, and frame_done SHALL pulse the cycle after wrap.
REQ-025 A WAIT_END cycle counter reaching END_TIMEOUT SHALL set wr_err, return to IDLE, and leave the burst counter unchanged.
REQ-026 user_wr_end outside WAIT_END SHALL be ignored.
REQ-027 wr_grant deasserting during BURST/DRAIN/WAIT_END SHALL NOT abort the burst.
REQ-028 wr_busy SHALL be high in BURST, DRAIN, WAIT_END.
REQ-029 From user_wr_end to the next wr_req SHALL take at least one IDLE cycle.

Reset
REQ-030 rst SHALL force IDLE asynchronously; fifo_rd_en, wr_req, wr_en, wr_busy, frame_done, wr_err, and all counters SHALL be 0.
REQ-031 wr_data has no reset and follows fifo_rd_data.
REQ-032 rst mid-burst SHALL drop wr_en immediately; the partial burst is not resumed and the frame restarts at burst 0.

Structure
REQ-033 State encoding, BURST_LEN, BURSTS_PER_FRAME, and END_TIMEOUT defaults SHALL live in shared package ddr_ctrl_pkg, which user_wr_ctrl also uses.
REQ-034 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-035 rd_count=64, grant tied high -> wr_req for 1 cycle; fifo_rd_en 64 cycles; wr_en 64 contiguous cycles lagging by 1; data order preserved.
REQ-036 rd_count=63 -> wr_req never asserts; raising to 64 -> REQ next cycle.
REQ-037 Grant delayed 20 cycles -> wr_req held 20 cycles, no FIFO reads; then normal burst.
REQ-038 1536 bursts, each acknowledged by user_wr_end -> frame_done exactly once, 1 cycle after the 1536th end; counter reads 0.
REQ-039 user_wr_end withheld -> wr_err set after 4096 WAIT_END cycles; IDLE; counter unchanged; wr_err stays 1 until rst.
REQ-040 rst asserted on beat 30 -> wr_en, fifo_rd_en, and wr_busy low in the same cycle; after release, the next burst starts from burst 0.
